// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared next-op encodings and default addresses for npc_unit
package npc_pkg;

    typedef enum logic [3:0] {
        NPC_SEQ  = 4'd0,
        NPC_BR   = 4'd1,
        NPC_J    = 4'd2,
        NPC_JR   = 4'd3,
        NPC_JAL  = 4'd4,
        NPC_JALR = 4'd5
    } npc_op_e;

    localparam logic [31:0] NPC_RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] NPC_EXC_VECTOR_DEF = 32'h0000_4180;

endpackage

// File: rtl/npc_ras.sv
// rtl/npc_ras.sv - circular return-address stack with overwrite-oldest on overflow
module npc_ras #(
    parameter int RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic [31:0] top,
    output logic        valid
);
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL = PTR_W'(RAS_DEPTH - 1) + (PTR_W+1)'(1);

    logic [31:0]    mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W:0]   count;

    // Top pointer names the most recent entry; a push pre-increments so the
    // oldest slot is reused once the buffer wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            ptr                  <= ptr + 1'b1;
            mem[ptr + 1'b1]      <= push_data;
            if (count != FULL) begin
                count <= count + 1'b1;
            end
        end else if (pop && count != '0) begin
            ptr   <= ptr - 1'b1;
            count <= count - 1'b1;
        end
    end

    assign valid = (count != '0);
    assign top   = valid ? mem[ptr] : 32'h0;

endmodule

// File: rtl/npc_unit.sv
// rtl/npc_unit.sv - MIPS program counter and next-PC selection; NPC_RAS_EN adds a jr-target RAS
module npc_unit
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = NPC_RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = NPC_EXC_VECTOR_DEF,
    parameter int          RAS_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        exc_req,
    input  logic [3:0]  next_op,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_val,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic [31:0] link_addr,
    output logic        misalign,
    output logic [31:0] pred_target,
    output logic        pred_valid,
    output logic        ras_miss
);
    logic [31:0] br_offset;
    logic        load_pc;

    assign link_addr = pc + 32'd4;
    assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};
    // Exceptions redirect even while the pipeline is stalled.
    assign load_pc   = exc_req | ~stall;

    // Next-PC mux; exception has priority over all flow ops, unknown ops act as SEQ.
    always_comb begin
        npc = link_addr;
        if (exc_req) begin
            npc = EXC_VECTOR;
        end else begin
            case (next_op)
                NPC_BR:             npc = br_taken ? (link_addr + br_offset) : link_addr;
                NPC_J, NPC_JAL:     npc = {pc[31:28], imm26, 2'b00};
                NPC_JR, NPC_JALR:   npc = rs_val;
                default:            npc = link_addr;
            endcase
        end
    end

    assign misalign = (npc[1:0] != 2'b00);

    // Architectural PC register; an unaligned target is still loaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load_pc) begin
            pc <= npc;
        end
    end

`ifdef NPC_RAS_EN
    logic ras_push;
    logic ras_pop;

    // Stack only moves on real, non-exception PC loads.
    assign ras_push = load_pc && !exc_req &&
                      (next_op == NPC_JAL || next_op == NPC_JALR);
    assign ras_pop  = load_pc && !exc_req && (next_op == NPC_JR);

    npc_ras #(
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (link_addr),
        .top       (pred_target),
        .valid     (pred_valid)
    );

    assign ras_miss = (next_op == NPC_JR) && pred_valid && (pred_target != rs_val);
`else
    assign pred_target = 32'h0;
    assign pred_valid  = 1'b0;
    assign ras_miss    = 1'b0;
`endif

endmodule

// File: doc/npc_unit.md
# npc_unit

Parametrised program-counter unit for the MIPS datapath. It holds the architectural PC register and computes the next fetch address for sequential, branch, jump and register-jump flow, plus an exception redirect. It adds a stall hold and an optional return-address stack (RAS) that predicts `jr` targets for the pipelined front end. It sits at the head of the fetch stage, between the control unit and instruction memory.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset
- `EXC_VECTOR`, 32'h0000_4180, exception entry address
- `RAS_DEPTH`, 4, RAS entries; must be a power of two, ≥2
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; one clock domain only
- `stall`  in  1  hold PC and RAS this cycle
- `exc_req`  in  1  redirect to `EXC_VECTOR`
- `next_op`  in  4  0 SEQ, 1 BR, 2 J, 3 JR, 4 JAL, 5 JALR, 6–15 treated as SEQ
- `br_taken`  in  1  branch condition, used only when `next_op`=1
- `imm16`  in  16  branch offset, words, signed
- `imm26`  in  26  jump index
- `rs_val`  in  32  register target for JR/JALR
- `pc`  out  32  current PC, registered
- `npc`  out  32  next PC, combinational
- `link_addr`  out  32  `pc`+4, written to the link register by JAL/JALR
- `misalign`  out  1  `npc[1:0]` ≠ 0
- `pred_target`  out  32  RAS top (NPC_RAS_EN only, else 0)
- `pred_valid`  out  1  RAS non-empty (NPC_RAS_EN only, else 0)
- `ras_miss`  out  1  JR with `pred_valid` and `pred_target` ≠ `rs_val`

## Operation
- npc selection, highest priority first: `exc_req` → `EXC_VECTOR`; BR & `br_taken` → `pc`+4+(sext(imm16)<<2); BR & !`br_taken` → `pc`+4; J/JAL → {`pc`[31:28], imm26, 2'b00}; JR/JALR → `rs_val`; otherwise `pc`+4.
- All additions are 32-bit modulo; wrap past 32'hFFFF_FFFC to 0 without a flag.
- `misalign` is flagged only. The PC still loads the unaligned value; the exception logic decides the outcome.
- RAS, circular buffer of `RAS_DEPTH` entries with a top pointer and a count:
  - push `link_addr` on JAL/JALR;
  - pop on JR;
  - push when full overwrites the oldest entry, and the count saturates at `RAS_DEPTH`;
  - pop when empty is a no-op, and the count stays 0.
- JALR is push-only, never a pop. One op per cycle, so push and pop never coincide.
- The RAS changes only on cycles where the PC loads. It does not change on `stall` cycles or `exc_req` cycles.

## Timing
- Reset (asynchronous): `pc`=`RESET_PC`, RAS count=0, pointer=0, entries=0. Therefore `pred_valid`=0, `pred_target`=0, `ras_miss`=0, `npc`=`RESET_PC`+4 for op SEQ.
- At posedge `clk`:
  - if `exc_req`: `pc` ← `npc` (this overrides `stall`);
  - else if !`stall`: `pc` ← `npc`;
  - else `pc` holds.
- `npc`, `link_addr`, `misalign` and `ras_miss` are combinational from the current inputs and `pc` (zero-cycle).
- `pred_target`/`pred_valid` reflect RAS state after the last edge. A push is visible one cycle later.
- Reset asserted mid-stall or mid-RAS-update wins immediately. No partial update survives.

## Configuration
- `NPC_RAS_EN` defined: the RAS is built; `pred_target`, `pred_valid` and `ras_miss` are live.
- `NPC_RAS_EN` undefined: the RAS is removed. These outputs are tied to 0, and the PC and `npc` behaviour is unchanged.

## Structure
- Shared package `npc_pkg` holds:
  - the `next_op` encodings (NPC_SEQ…NPC_JALR);
  - the default `RESET_PC`/`EXC_VECTOR` constants.
- One sub-module, `npc_ras`: parametrised on `RAS_DEPTH`, with push/pop/top/valid ports, instantiated under `NPC_RAS_EN`.

## Test plan
- Reset, then 3 SEQ cycles → `pc` 0x3000, 0x3004, 0x3008, 0x300C.
- `pc`=0x3010, BR, taken, imm16=0xFFFE → `npc`=0x300C. Same with `br_taken`=0 → `npc`=0x3014.
- `pc`=0x3000, JAL, imm26=0x0000C10 → `npc`=0x3040, `link_addr`=0x3004. Next cycle `pred_valid`=1, `pred_target`=0x3004. Then JR, `rs_val`=0x3004 → `ras_miss`=0 and the RAS empties.
- Five JALs with RAS_DEPTH=4, then five JRs → the first four pops return the last four link addresses in LIFO order. The fifth JR sees `pred_valid`=0 and `ras_miss`=0.
- `stall`=1 with a JAL op for 2 cycles → `pc` and RAS unchanged. Then `stall`=1 with `exc_req`=1 → `pc`=0x4180 and RAS unchanged.
- JR, `rs_val`=0x3002 → `misalign`=1 and `pc` loads 0x3002. Reset asserted between edges → `pc`=0x3000 immediately.
